fetch_controller: RTL and testbench

//  Instruction-fetch sequencer. Owns the fetch PC, issues one-at-a-time requests to

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 46 ++++
 rtl/fetch_controller.sv | 117 +++++++++++
 tb/tb_fetch_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  // Bytes per instruction word; the fetch PC advances by this amount.
  localparam int unsigned INSTR_BYTES = 4;

  // Low address bits that are forced to zero on redirect targets.
  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {pc, instr} holding register between imem responses and decode.
`timescale 1ns/1ps
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [DATA_W-1:0] load_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
);

  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;

  // Flush beats load beats drain; the payload only changes on load so it stays stable while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= load_pc;
      instr_q <= load_instr;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch PC, issues single outstanding imem
// requests, buffers responses for decode and applies branch/jump redirects.
`timescale 1ns/1ps
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              drop_q, drop_d;
  logic              buf_valid;
  logic              buf_load;
  logic              req_xfer;

  // State, fetch PC, in-flight request PC and stale-response flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      req_pc_q <= RESET_VECTOR;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  // Request gating, next-state logic and redirect handling (redirect has top priority on pc).
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    drop_d         = drop_q;
    buf_load       = 1'b0;
    // Only request when the single buffer entry is free or leaving this cycle,
    // so every kept response is guaranteed a slot.
    imem_req_valid = (state_q == S_REQ) && !halt && (!buf_valid || if_ready);
    req_xfer       = imem_req_valid && imem_req_ready;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_xfer) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(INSTR_BYTES);
          state_d  = S_WAIT;
          // A request accepted alongside a redirect fetches the old path.
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d  = S_REQ;
          drop_d   = 1'b0;
          buf_load = !drop_q && !redirect_valid;
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_d = redirect_addr & ~ADDR_W'(ADDR_ALIGN_MASK);
    end

    busy = ((state_q == S_REQ) && imem_req_valid) || (state_q == S_WAIT);
  end

  assign imem_req_addr = pc_q;

  fetch_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .load      (buf_load),
    .load_pc   (req_pc_q),
    .load_instr(imem_rsp_data),
    .out_valid (buf_valid),
    .out_ready (if_ready),
    .out_pc    (if_pc),
    .out_instr (if_instr)
  );

  assign if_valid = buf_valid;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: vector table, directed corner cases,
// and randomized traffic against a PC-stream reference model.
`timescale 1ns/1ps
module tb_fetch_controller;

  localparam logic [31:0] RV2 = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        halt, redirect_valid, imem_req_ready, imem_rsp_valid, if_ready;
  logic [31:0] redirect_addr, imem_rsp_data;
  logic        imem_req_valid, if_valid, busy;
  logic [31:0] imem_req_addr, if_pc, if_instr;
  logic        req_valid2, if_valid2, busy2;
  logic [31:0] req_addr2, if_pc2, if_instr2;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_acc = '0;

  fetch_controller #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .busy(busy)
  );

  fetch_controller #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(RV2)) dut2 (
    .clk(clk), .reset_n(reset_n), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .imem_req_valid(req_valid2),
    .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr2),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid2), .if_ready(if_ready), .if_pc(if_pc2), .if_instr(if_instr2),
    .busy(busy2)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Record the accepted address (for response data) and move to just after the next edge.
  task automatic adv();
    if (imem_req_valid && imem_req_ready) last_acc = imem_req_addr;
    @(posedge clk);
    #1;
  endtask

  // Drive response/redirect for this cycle, then wait to the mid-cycle sample point.
  task automatic cyc(input logic rv, input logic rd, input logic [31:0] ra);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? instr_of(last_acc) : 32'hDEAD_BEEF;
    redirect_valid = rd;
    redirect_addr  = ra;
    #4;
  endtask

  // Called just after a posedge; returns in the first cycle after release (S_IDLE).
  task automatic do_reset();
    reset_n = 1'b0;
    halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #4;
    chk1 ("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_req_addr",  imem_req_addr, 32'h0);
    chk32("rst_req_addr2", req_addr2, RV2);
    chk1 ("rst_if_valid",  if_valid, 1'b0);
    chk32("rst_if_pc",     if_pc, 32'h0);
    chk32("rst_if_instr",  if_instr, 32'h0);
    chk1 ("rst_busy",      busy, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    last_acc = '0;
  endtask

  typedef struct {
    logic        rsp;
    logic        rv;
    logic [31:0] ra;
    logic        iv;
    logic [31:0] ipc;
    logic        bsy;
  } vec_t;

  vec_t tbl[8];

  // Random-phase reference state
  logic [31:0] fetch_pc, exp_pc, pend_addr;
  logic        pending, prev_redir, prev_hold, xfer, cons;
  int          wdly, consumed;

  initial begin
    reset_n = 1'b1;
    halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    imem_req_ready = 1'b0; if_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Steady streaming from reset: ready=1, 1-cycle response, decode always ready.
    tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'hC, 1'b0, 32'h0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 1'b1};

    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rsp, 1'b0, 32'h0);
      chk1 ("tbl_req_valid", imem_req_valid, tbl[i].rv);
      chk32("tbl_req_addr",  imem_req_addr, tbl[i].ra);
      chk1 ("tbl_if_valid",  if_valid, tbl[i].iv);
      chk1 ("tbl_busy",      busy, tbl[i].bsy);
      chk1 ("wrap_req_valid", req_valid2, tbl[i].rv);
      chk32("wrap_req_addr",  req_addr2, tbl[i].ra + RV2);
      chk1 ("wrap_busy",      busy2, tbl[i].bsy);
      if (tbl[i].iv) begin
        chk32("tbl_if_pc",     if_pc, tbl[i].ipc);
        chk32("tbl_if_instr",  if_instr, instr_of(tbl[i].ipc));
        chk1 ("wrap_if_valid", if_valid2, 1'b1);
        chk32("wrap_if_pc",    if_pc2, tbl[i].ipc + RV2);
        chk32("wrap_if_instr", if_instr2, instr_of(tbl[i].ipc));
      end
      adv();
    end

    // Decode stall: entry held, no new request until it drains.
    do_reset();
    if_ready = 1'b0;
    cyc(0, 0, 0); adv();
    cyc(0, 0, 0); chk32("st_req_addr0", imem_req_addr, 32'h0); adv();
    cyc(1, 0, 0); adv();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0);
      chk1 ("st_if_valid", if_valid, 1'b1);
      chk32("st_if_pc", if_pc, 32'h0);
      chk32("st_if_instr", if_instr, instr_of(32'h0));
      chk1 ("st_no_req", imem_req_valid, 1'b0);
      chk1 ("st_busy", busy, 1'b0);
      adv();
    end
    if_ready = 1'b1;
    cyc(0, 0, 0); chk1("st_drain_req", imem_req_valid, 1'b1); chk32("st_drain_addr", imem_req_addr, 32'h4); adv();
    if_ready = 1'b0;
    cyc(0, 0, 0); chk1("st_drained", if_valid, 1'b0); chk1("st_wait_busy", busy, 1'b1); adv();
    cyc(1, 0, 0); adv();
    cyc(0, 0, 0); chk1("st_next_valid", if_valid, 1'b1); chk32("st_next_pc", if_pc, 32'h4); adv();

    // Redirect while waiting for 0x8, then redirect with response, then with accept+drain.
    do_reset();
    cyc(0, 0, 0); adv();
    cyc(0, 0, 0); adv();
    cyc(1, 0, 0); adv();
    cyc(0, 0, 0); adv();
    cyc(1, 0, 0); adv();
    cyc(0, 0, 0); chk32("rd_req8", imem_req_addr, 32'h8); adv();
    cyc(0, 1, 32'h103); chk1("rd_wait_busy", busy, 1'b1); chk1("rd_wait_noreq", imem_req_valid, 1'b0); adv();
    cyc(1, 0, 0); chk1("rd_flushed", if_valid, 1'b0); adv();
    cyc(0, 0, 0); chk1("rd_no_stale", if_valid, 1'b0); chk1("rd_req_v", imem_req_valid, 1'b1);
    chk32("rd_req_target", imem_req_addr, 32'h100); adv();
    cyc(1, 0, 0); chk1("rd_empty", if_valid, 1'b0); adv();
    cyc(0, 0, 0); chk1("rd_tgt_valid", if_valid, 1'b1); chk32("rd_tgt_pc", if_pc, 32'h100);
    chk32("rd_tgt_instr", if_instr, instr_of(32'h100)); adv();
    cyc(1, 1, 32'h200); adv();
    cyc(0, 0, 0); chk1("rr_empty", if_valid, 1'b0); chk32("rr_req_target", imem_req_addr, 32'h200); adv();
    cyc(1, 0, 0); adv();
    cyc(0, 1, 32'h300); chk1("rx_if_valid", if_valid, 1'b1); chk32("rx_if_pc", if_pc, 32'h200);
    chk1("rx_req_v", imem_req_valid, 1'b1); chk32("rx_req_addr", imem_req_addr, 32'h204); adv();
    cyc(0, 1, 32'h400); chk1("rx_flushed", if_valid, 1'b0); chk1("rx_wait", busy, 1'b1); adv();
    cyc(1, 0, 0); chk1("rx_no_stale", if_valid, 1'b0); adv();
    cyc(0, 0, 0); chk1("rx_empty", if_valid, 1'b0); chk32("rx_req_last", imem_req_addr, 32'h400); adv();
    cyc(1, 0, 0); adv();
    cyc(0, 0, 0); chk1("rx_tgt_valid", if_valid, 1'b1); chk32("rx_tgt_pc", if_pc, 32'h400);
    chk32("rx_tgt_instr", if_instr, instr_of(32'h400)); adv();

    // Halt during a fetch, then async reset mid-fetch with a late response.
    do_reset();
    cyc(0, 0, 0); adv();
    cyc(0, 0, 0); chk32("h_req0", imem_req_addr, 32'h0); adv();
    halt = 1'b1;
    cyc(1, 0, 0); adv();
    cyc(0, 0, 0); chk1("h_captured", if_valid, 1'b1); chk32("h_pc", if_pc, 32'h0);
    chk1("h_no_req", imem_req_valid, 1'b0); chk1("h_busy", busy, 1'b0); adv();
    cyc(0, 0, 0); chk1("h_no_req2", imem_req_valid, 1'b0); adv();
    halt = 1'b0;
    cyc(0, 0, 0); chk1("h_resume", imem_req_valid, 1'b1); chk32("h_resume_addr", imem_req_addr, 32'h4); adv();
    do_reset();
    cyc(1, 0, 0); chk1("lr_idle_noreq", imem_req_valid, 1'b0); adv();
    cyc(1, 0, 0); chk1("lr_req", imem_req_valid, 1'b1); chk32("lr_req_addr", imem_req_addr, 32'h0);
    chk1("lr_ignored", if_valid, 1'b0); adv();
    cyc(0, 0, 0); chk1("lr_ignored2", if_valid, 1'b0); chk1("lr_busy", busy, 1'b1); adv();
    cyc(1, 0, 0); adv();
    cyc(0, 0, 0); chk1("lr_valid", if_valid, 1'b1); chk32("lr_pc", if_pc, 32'h0);
    chk32("lr_instr", if_instr, instr_of(32'h0)); adv();

    // Randomized traffic against a PC-stream model.
    do_reset();
    fetch_pc = 32'h0; exp_pc = 32'h0; pending = 1'b0; pend_addr = '0; wdly = 0;
    prev_redir = 1'b0; prev_hold = 1'b0; consumed = 0;
    for (int n = 0; n < 3000; n++) begin
      halt           = halt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 31) == 0);
      redirect_valid = ($urandom_range(0, 23) == 0);
      redirect_addr  = $urandom;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      if (pending && wdly == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      #4;
      xfer = imem_req_valid & imem_req_ready;
      cons = if_valid & if_ready;
      if (halt) chk1("r_halt_gate", imem_req_valid, 1'b0);
      if (pending) begin
        chk1("r_one_outstanding", imem_req_valid, 1'b0);
        chk1("r_busy_wait", busy, 1'b1);
      end
      if (prev_redir) chk1("r_flush", if_valid, 1'b0);
      if (prev_hold) begin
        chk1 ("r_hold_valid", if_valid, 1'b1);
        chk32("r_hold_pc", if_pc, exp_pc);
      end
      if (xfer) chk32("r_req_addr", imem_req_addr, fetch_pc);
      if (cons && !redirect_valid) begin
        chk32("r_if_pc", if_pc, exp_pc);
        chk32("r_if_instr", if_instr, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_redir = redirect_valid;
      prev_hold  = if_valid & !if_ready & !redirect_valid;
      if (redirect_valid) begin
        fetch_pc = redirect_addr & ~32'h3;
        exp_pc   = redirect_addr & ~32'h3;
      end else if (xfer) begin
        fetch_pc = fetch_pc + 32'd4;
      end
      if (imem_rsp_valid) pending = 1'b0;
      else if (pending) wdly--;
      if (xfer) begin
        pending   = 1'b1;
        pend_addr = imem_req_addr;
        wdly      = $urandom_range(0, 2);
      end
      adv();
    end
    chk1("r_progress", consumed >= 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
